// File: rtl/riscv_fetch_unit_pkg.sv
// Shared fetch-stage definitions: opcode constants used by decode/control,
// the architectural NOP word, fetch FSM state encoding and a small PC helper.
package riscv_fetch_unit_pkg;

  // Base RV32I major opcodes, shared with the control unit
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // addi x0,x0,0 -- presented to decode whenever no instruction is valid
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Fetch FSM state encoding
  typedef enum logic [1:0] {
    FS_FETCH = 2'b00,
    FS_HOLD  = 2'b01,
    FS_DRAIN = 2'b10
  } fetch_state_e;

  // Force an address onto a 32-bit word boundary
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/riscv_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between fetch and imem.
interface riscv_fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  // Fetch unit drives the request side
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  // Instruction memory answers the request
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/riscv_pc_next.sv
// Next-PC selection for the fetch stage: sequential pc+4 or the word-aligned
// redirect target, plus detection of a misaligned redirect target.
module riscv_pc_next
  import riscv_fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_next,
  output logic        misalign
);

  logic [31:0] pc_plus4_s;
  logic [31:0] target_s;

  // Wraps modulo 2^32 with no carry-out; the top word simply rolls over to zero
  assign pc_plus4_s = pc + 32'd4;
  assign target_s   = align_word(redirect_pc);

  // Redirect always wins over sequential flow
  always_comb begin
    pc_next  = pc_plus4_s;
    misalign = 1'b0;
    if (redirect_valid) begin
      pc_next  = target_s;
      misalign = (redirect_pc[1:0] != 2'b00);
    end else begin
      pc_next  = pc_plus4_s;
      misalign = 1'b0;
    end
  end

endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction fetch stage. Owns the PC, issues one imem request at a time and
// hands each returned word to decode, holding it while decode stalls. A
// redirect that arrives while a request is outstanding parks the FSM in DRAIN
// so the stale response is swallowed before fetching at the new target.
module riscv_fetch_unit
  import riscv_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  riscv_fetch_unit_if.master        imem,
  input  logic                      redirect_valid,
  input  logic [31:0]               redirect_pc,
  input  logic                      stall,
  output logic                      inst_valid,
  output logic [31:0]               inst,
  output logic [31:0]               inst_pc,
  output logic [6:0]                opcode,
  output logic                      misalign_err
);

  fetch_state_e state_r, state_s;
  logic [31:0]  pc_r, pc_s;
  logic [31:0]  addr_r, addr_s;
  logic [31:0]  inst_r, inst_s;
  logic [31:0]  inst_pc_r, inst_pc_s;
  logic         inst_valid_r, inst_valid_s;
  logic         misalign_r, misalign_s;

  logic [31:0]  pc_next_w;
  logic         misalign_w;

  riscv_pc_next u_pc_next (
    .pc             (pc_r),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc_next        (pc_next_w),
    .misalign       (misalign_w)
  );

  // Request is a pure function of state, killed immediately by reset so the
  // memory sees the abort in the same cycle
  assign imem.imem_req  = !rst && ((state_r == FS_FETCH) || (state_r == FS_DRAIN));
  assign imem.imem_addr = addr_r;

  assign inst_valid   = inst_valid_r;
  assign inst         = inst_r;
  assign inst_pc      = inst_pc_r;
  assign opcode       = inst_r[6:0];
  assign misalign_err = misalign_r;

  // Next-state and next-datapath values; redirect outranks stall and ack
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    addr_s       = addr_r;
    inst_s       = inst_r;
    inst_pc_s    = inst_pc_r;
    inst_valid_s = inst_valid_r;
    misalign_s   = misalign_w;

    if (redirect_valid) begin
      pc_s         = pc_next_w;
      inst_valid_s = 1'b0;
      inst_s       = NOP_INST;
      case (state_r)
        FS_FETCH, FS_DRAIN: begin
          if (imem.imem_ack) begin
            // Outstanding request finished this cycle: drop its data, go straight to target
            state_s = FS_FETCH;
            addr_s  = pc_next_w;
          end else begin
            // Request still in flight: its address must stay put until it completes
            state_s = FS_DRAIN;
            addr_s  = addr_r;
          end
        end
        FS_HOLD: begin
          state_s = FS_FETCH;
          addr_s  = pc_next_w;
        end
        default: begin
          state_s = FS_FETCH;
          addr_s  = pc_next_w;
        end
      endcase
    end else begin
      case (state_r)
        FS_FETCH: begin
          if (imem.imem_ack) begin
            inst_s       = imem.imem_rdata;
            inst_pc_s    = pc_r;
            pc_s         = pc_next_w;
            addr_s       = pc_next_w;
            inst_valid_s = 1'b1;
            state_s      = FS_HOLD;
          end else begin
            state_s = FS_FETCH;
          end
        end
        FS_HOLD: begin
          if (!stall) begin
            inst_valid_s = 1'b0;
            inst_s       = NOP_INST;
            state_s      = FS_FETCH;
          end else begin
            state_s = FS_HOLD;
          end
        end
        FS_DRAIN: begin
          if (imem.imem_ack) begin
            // Stale word discarded; addr now follows the redirected pc
            addr_s  = pc_r;
            state_s = FS_FETCH;
          end else begin
            state_s = FS_DRAIN;
          end
        end
        default: begin
          inst_valid_s = 1'b0;
          inst_s       = NOP_INST;
          addr_s       = pc_r;
          state_s      = FS_FETCH;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= FS_FETCH;
      pc_r         <= RESET_PC;
      addr_r       <= RESET_PC;
      inst_r       <= NOP_INST;
      inst_pc_r    <= 32'h0000_0000;
      inst_valid_r <= 1'b0;
      misalign_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      addr_r       <= addr_s;
      inst_r       <= inst_s;
      inst_pc_r    <= inst_pc_s;
      inst_valid_r <= inst_valid_s;
      misalign_r   <= misalign_s;
    end
  end

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Directed bench for riscv_fetch_unit: a behavioural imem with configurable
// wait states, a scoreboard of words expected to reach decode, and targeted
// checks on redirect, stall, misalignment, PC wrap and reset abort.
module tb_riscv_fetch_unit;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  opcode;
  logic        misalign_err;

  riscv_fetch_unit_if mif ();

  riscv_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem           (mif.master),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .opcode         (opcode),
    .misalign_err   (misalign_err)
  );

  localparam logic [31:0] NOP = 32'h0000_0013;

  int tests = 0;
  int fails = 0;

  int wait_cfg = 0;
  int wait_cnt = 0;
  bit drain    = 1'b0;
  bit prev_valid = 1'b0;
  logic [63:0] exp_q[$];

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // hard stop in case the sequence ever wedges
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h0050_0093;
    else return {a[24:0], 7'b1101111};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one clock: memory response from current req, scoreboard push, edge, scoreboard pop
  task automatic step();
    logic [63:0] e;
    #1;
    if (mif.imem_req && wait_cnt == wait_cfg) begin
      mif.imem_ack   = 1'b1;
      mif.imem_rdata = mem_word(mif.imem_addr);
      if (!rst && !redirect_valid && !drain)
        exp_q.push_back({mif.imem_addr, mem_word(mif.imem_addr)});
      wait_cnt = 0;
      drain    = 1'b0;
    end else begin
      mif.imem_ack   = 1'b0;
      mif.imem_rdata = 32'hDEAD_BEEF;
      if (mif.imem_req) wait_cnt++;
      else wait_cnt = 0;
      if (!rst && redirect_valid && mif.imem_req) drain = 1'b1;
      if (rst) drain = 1'b0;
    end
    prev_valid = inst_valid;
    @(posedge clk);
    #1;
    mif.imem_ack = 1'b0;
    if (inst_valid && !prev_valid) begin
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL sb_unexpected: observed inst %h pc %h expected no delivery", inst, inst_pc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_inst", inst, e[31:0]);
        check("sb_pc", inst_pc, e[63:32]);
        check("sb_opcode", {25'd0, opcode}, {25'd0, e[6:0]});
      end
    end
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
    mif.imem_ack = 1'b0; mif.imem_rdata = 32'h0;
    step(); step();

    // reset state
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst", inst, NOP);
    check("rst_pc", inst_pc, 32'h0);
    check("rst_misalign", {31'd0, misalign_err}, 32'd0);
    check("rst_req", {31'd0, mif.imem_req}, 32'd0);
    rst = 1'b0; #1;
    check("first_req", {31'd0, mif.imem_req}, 32'd1);
    check("first_addr", mif.imem_addr, 32'h0);

    // zero-wait fetch at 0
    step();
    check("t1_valid", {31'd0, inst_valid}, 32'd1);
    check("t1_opcode", {25'd0, opcode}, {25'd0, 7'b0010011});
    check("t1_req_hold", {31'd0, mif.imem_req}, 32'd0);
    step();
    check("t1_valid_drop", {31'd0, inst_valid}, 32'd0);
    check("t1_inst_nop", inst, NOP);
    check("t1_next_addr", mif.imem_addr, 32'h4);

    // stall for three cycles in HOLD
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_valid", {31'd0, inst_valid}, 32'd1);
      check("stall_inst", inst, mem_word(32'h4));
      check("stall_pc", inst_pc, 32'h4);
      check("stall_req", {31'd0, mif.imem_req}, 32'd0);
    end
    stall = 1'b0;
    step();
    check("stall_rel_req", {31'd0, mif.imem_req}, 32'd1);
    check("stall_rel_addr", mif.imem_addr, 32'h8);

    // 2-wait memory, redirect in first FETCH cycle -> DRAIN
    wait_cfg = 2;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    step();
    redirect_valid = 1'b0;
    check("drain_req", {31'd0, mif.imem_req}, 32'd1);
    check("drain_addr0", mif.imem_addr, 32'h8);
    check("drain_valid", {31'd0, inst_valid}, 32'd0);
    step();
    check("drain_addr1", mif.imem_addr, 32'h8);
    step();
    check("drain_done_addr", mif.imem_addr, 32'h100);
    check("drain_done_valid", {31'd0, inst_valid}, 32'd0);
    wait_cfg = 0;
    step();
    step();
    check("post_drain_addr", mif.imem_addr, 32'h104);

    // misaligned redirect coinciding with ack
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
    step();
    redirect_valid = 1'b0;
    check("mis_pulse", {31'd0, misalign_err}, 32'd1);
    check("mis_addr", mif.imem_addr, 32'h100);
    check("mis_valid", {31'd0, inst_valid}, 32'd0);
    step();
    check("mis_clear", {31'd0, misalign_err}, 32'd0);

    // redirect from HOLD (overriding stall) to the top word, then wrap
    stall = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0; stall = 1'b0;
    check("top_addr", mif.imem_addr, 32'hFFFF_FFFC);
    check("top_valid", {31'd0, inst_valid}, 32'd0);
    check("top_misalign", {31'd0, misalign_err}, 32'd0);
    step();
    step();
    check("wrap_addr", mif.imem_addr, 32'h0);

    // reset while a request is pending
    step();
    step();
    check("pre_rst_addr", mif.imem_addr, 32'h4);
    wait_cfg = 2;
    step();
    rst = 1'b1; #1;
    check("rst_mid_req", {31'd0, mif.imem_req}, 32'd0);
    check("rst_mid_valid", {31'd0, inst_valid}, 32'd0);
    step();
    rst = 1'b0; #1;
    check("restart_req", {31'd0, mif.imem_req}, 32'd1);
    check("restart_addr", mif.imem_addr, 32'h0);
    step(); step(); step();
    check("restart_valid", {31'd0, inst_valid}, 32'd1);
    check("restart_inst", inst, 32'h0050_0093);

    tests++;
    assert (exp_q.size() == 0) else begin
      fails++;
      $error("FAIL sb_leftover: observed %0d pending expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
